// File: rtl/comms_uart_ctrl.sv
// Chip serial controller: UART RX/TX on one clock, packet decode to the register map,
// forwarding of foreign packets, event packing for the FIFO and TX arbitration.
module comms_uart_ctrl #(
    parameter int WIDTH        = 54,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx_in,
    output logic             tx_out,
    input  logic [5:0]       chip_id,
    input  logic [WIDTH-2:0] pre_event,
    input  logic             load_event,
    output logic [WIDTH-1:0] finished_event,
    output logic             write_fifo_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             read_fifo_n,
    output logic [7:0]       regmap_address,
    output logic [7:0]       regmap_write_data,
    output logic             write_regmap,
    input  logic [7:0]       regmap_read_data
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_READ, TX_LOAD, TX_SEND} tx_state_t;

    rx_state_t        rx_state_reg, rx_state_next;
    tx_state_t        tx_state_reg, tx_state_next;
    logic             rx_meta_reg, rx_sync_reg;
    logic [CW-1:0]    rx_cnt_reg, tx_cnt_reg;
    logic [BW-1:0]    rx_bits_reg, tx_bits_reg;
    logic [WIDTH-1:0] rx_shift_reg, tx_frame_reg, pend_data_reg, finished_event_reg;
    logic             rx_valid_reg, pend_valid_reg, rd_pend_reg;
    logic             tx_out_reg, read_fifo_n_reg, write_fifo_n_reg, write_regmap_reg;
    logic [7:0]       regmap_address_reg, regmap_write_data_reg;

    logic             rx_bit_end, rx_half, tx_bit_end, parity_ok, for_us;
    logic             pend_take, fifo_take, pend_push;
    logic [WIDTH-1:0] pend_push_data;
    logic [WIDTH-2:0] reply_x, event_x;
    logic             ev_low_unused;

    assign rx_bit_end = (rx_cnt_reg == CW'(CLKS_PER_BIT - 1));
    assign rx_half    = (rx_cnt_reg == CW'(HALF - 1));
    assign tx_bit_end = (tx_cnt_reg == CW'(CLKS_PER_BIT - 1));
    // A valid word carries an odd number of ones across all WIDTH bits.
    assign parity_ok  = ^rx_shift_reg;
    assign for_us     = (rx_shift_reg[7:2] == chip_id);
    assign reply_x    = {{(WIDTH-25){1'b0}}, regmap_read_data, regmap_address_reg, chip_id, 2'b11};
    assign event_x    = {pre_event[WIDTH-2:8], chip_id, 2'b01};
    assign ev_low_unused = ^pre_event[7:0];

    // ---------------- RX ----------------
    always_comb begin
        rx_state_next = rx_state_reg;
        case (rx_state_reg)
            RX_IDLE:  if (!rx_sync_reg) rx_state_next = RX_START;
            RX_START: if (rx_half) rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_bit_end && rx_bits_reg == BW'(WIDTH - 1)) rx_state_next = RX_STOP;
            RX_STOP:  if (rx_bit_end) rx_state_next = RX_IDLE;
            default:  rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bits_reg  <= '0;
            rx_shift_reg <= '0;
            rx_valid_reg <= 1'b0;
        end else begin
            rx_meta_reg  <= rx_in;
            rx_sync_reg  <= rx_meta_reg;
            rx_state_reg <= rx_state_next;
            rx_valid_reg <= 1'b0;
            if (rx_state_reg == RX_IDLE || rx_state_next != rx_state_reg || rx_bit_end)
                rx_cnt_reg <= '0;
            else
                rx_cnt_reg <= rx_cnt_reg + 1'b1;
            if (rx_state_reg == RX_START)
                rx_bits_reg <= '0;
            if (rx_state_reg == RX_DATA && rx_bit_end) begin
                rx_shift_reg <= {rx_sync_reg, rx_shift_reg[WIDTH-1:1]};
                rx_bits_reg  <= rx_bits_reg + 1'b1;
            end
            // A low stop bit is a framing error: the word never becomes valid.
            if (rx_state_reg == RX_STOP && rx_bit_end)
                rx_valid_reg <= rx_sync_reg;
        end
    end

    // ---------------- Decode, pending slot, event packing ----------------
    always_comb begin
        pend_push      = 1'b0;
        pend_push_data = rx_shift_reg;
        if (rx_valid_reg && parity_ok && !for_us) begin
            pend_push = 1'b1;
        end else if (rd_pend_reg) begin
            pend_push      = 1'b1;
            pend_push_data = {~^reply_x, reply_x};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            regmap_address_reg    <= '0;
            regmap_write_data_reg <= '0;
            write_regmap_reg      <= 1'b0;
            rd_pend_reg           <= 1'b0;
            pend_valid_reg        <= 1'b0;
            pend_data_reg         <= '0;
            finished_event_reg    <= '0;
            write_fifo_n_reg      <= 1'b1;
        end else begin
            write_regmap_reg <= 1'b0;
            rd_pend_reg      <= 1'b0;
            if (rx_valid_reg && parity_ok && for_us) begin
                if (rx_shift_reg[1:0] == 2'b10) begin
                    regmap_address_reg    <= rx_shift_reg[15:8];
                    regmap_write_data_reg <= rx_shift_reg[23:16];
                    write_regmap_reg      <= 1'b1;
                end else if (rx_shift_reg[1:0] == 2'b11) begin
                    regmap_address_reg <= rx_shift_reg[15:8];
                    rd_pend_reg        <= 1'b1;
                end
            end
            // Take and push never coincide: take needs a full slot, push an empty one.
            if (pend_take)
                pend_valid_reg <= 1'b0;
            if (pend_push && !pend_valid_reg) begin
                pend_valid_reg <= 1'b1;
                pend_data_reg  <= pend_push_data;
            end
            write_fifo_n_reg <= ~load_event;
            if (load_event)
                finished_event_reg <= {~^event_x, event_x};
        end
    end

    // ---------------- TX ----------------
    assign pend_take = (tx_state_reg == TX_IDLE) && pend_valid_reg;
    assign fifo_take = (tx_state_reg == TX_IDLE) && !pend_valid_reg && !fifo_empty;

    always_comb begin
        tx_state_next = tx_state_reg;
        case (tx_state_reg)
            TX_IDLE: begin
                if (pend_valid_reg)   tx_state_next = TX_SEND;
                else if (!fifo_empty) tx_state_next = TX_READ;
            end
            TX_READ: tx_state_next = TX_LOAD;
            TX_LOAD: tx_state_next = TX_SEND;
            TX_SEND: if (tx_bit_end && tx_bits_reg == BW'(WIDTH + 1)) tx_state_next = TX_IDLE;
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_state_reg    <= TX_IDLE;
            tx_cnt_reg      <= '0;
            tx_bits_reg     <= '0;
            tx_frame_reg    <= '0;
            tx_out_reg      <= 1'b1;
            read_fifo_n_reg <= 1'b1;
        end else begin
            tx_state_reg    <= tx_state_next;
            read_fifo_n_reg <= ~fifo_take;
            if (tx_state_reg != TX_SEND || tx_bit_end)
                tx_cnt_reg <= '0;
            else
                tx_cnt_reg <= tx_cnt_reg + 1'b1;
            if (pend_take || tx_state_reg == TX_LOAD) begin
                tx_frame_reg <= pend_take ? pend_data_reg : fifo_data;
                tx_out_reg   <= 1'b0;
                tx_bits_reg  <= '0;
            end else if (tx_state_reg == TX_SEND && tx_bit_end) begin
                // Ones shifted in behind the data supply the stop bit.
                if (tx_bits_reg == BW'(WIDTH + 1)) begin
                    tx_out_reg <= 1'b1;
                end else begin
                    tx_out_reg   <= tx_frame_reg[0];
                    tx_frame_reg <= {1'b1, tx_frame_reg[WIDTH-1:1]};
                    tx_bits_reg  <= tx_bits_reg + 1'b1;
                end
            end
        end
    end

    assign tx_out            = tx_out_reg;
    assign read_fifo_n       = read_fifo_n_reg;
    assign write_fifo_n      = write_fifo_n_reg;
    assign finished_event    = finished_event_reg;
    assign regmap_address    = regmap_address_reg;
    assign regmap_write_data = regmap_write_data_reg;
    assign write_regmap      = write_regmap_reg;
endmodule

// File: tb/tb_comms_uart_ctrl.sv
// Scoreboard bench for comms_uart_ctrl: expected writes, events and TX frames are queued
// by the stimulus; independent monitors pop and compare whenever the DUT produces output.
`timescale 1ns/1ps
module tb_comms_uart_ctrl;
    localparam int W   = 54;
    localparam int CPB = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         rx_in = 1'b1;
    logic         tx_out;
    logic [5:0]   chip_id = 6'h04;
    logic [W-2:0] pre_event = '0;
    logic         load_event = 1'b0;
    logic [W-1:0] finished_event;
    logic         write_fifo_n;
    logic         fifo_empty = 1'b1;
    logic [W-1:0] fifo_data = '0;
    logic         read_fifo_n;
    logic [7:0]   regmap_address, regmap_write_data, regmap_read_data;
    logic         write_regmap;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_tx[$];
    logic [15:0]  exp_wr[$];
    logic [W-1:0] exp_ev[$];
    int   tx_starts = 0, tx_frames = 0, n_regwr = 0, n_evwr = 0, n_rd = 0;
    logic lb_busy = 1'b0;
    logic [W-1:0] fifo_word = 54'h2A_5555_0000_0001;

    always #5 clk = ~clk;

    // Register map model: only address 03 holds a nonzero value.
    assign regmap_read_data = (regmap_address == 8'h03) ? 8'hA5 : 8'h00;

    comms_uart_ctrl #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset_n(reset_n), .rx_in(rx_in), .tx_out(tx_out),
        .chip_id(chip_id), .pre_event(pre_event), .load_event(load_event),
        .finished_event(finished_event), .write_fifo_n(write_fifo_n),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .read_fifo_n(read_fifo_n),
        .regmap_address(regmap_address), .regmap_write_data(regmap_write_data),
        .write_regmap(write_regmap), .regmap_read_data(regmap_read_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected output %h, nothing queued", name, act);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int b = 0; b < W; b++) begin
            rx_in = w[b];
            repeat (CPB) @(negedge clk);
        end
        rx_in = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int c;
        c = 0;
        while (tx_frames < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("frames_seen", tx_frames, n);
    endtask

    // Register-write monitor
    initial forever begin
        @(negedge clk);
        if (reset_n && write_regmap === 1'b1) begin
            n_regwr++;
            if (exp_wr.size() == 0) unexpected("regwr", {regmap_address, regmap_write_data});
            else check("regwr_addr_data", {regmap_address, regmap_write_data}, exp_wr.pop_front());
        end
    end

    // Event FIFO write monitor
    initial forever begin
        @(negedge clk);
        if (reset_n && write_fifo_n === 1'b0) begin
            n_evwr++;
            if (exp_ev.size() == 0) unexpected("event_write", finished_event);
            else check("event_word", finished_event, exp_ev.pop_front());
        end
    end

    // FIFO read responder: data presented for the cycle after the strobe
    initial forever begin
        @(negedge clk);
        if (reset_n && read_fifo_n === 1'b0) begin
            n_rd++;
            check("read_while_tx_idle", lb_busy, 0);
            fifo_data = fifo_word;
            @(negedge clk);
            check("read_pulse_width", read_fifo_n, 1);
            @(negedge clk);
            fifo_data = '0;
        end
    end

    // Loopback UART receiver on tx_out
    initial begin
        logic [W-1:0] word;
        logic abort, stop_bit;
        word = '0;
        forever begin
            @(negedge clk);
            if (reset_n && tx_out === 1'b0) begin
                lb_busy = 1'b1;
                abort = 1'b0;
                tx_starts++;
                for (int i = 0; i < CPB/2; i++) begin
                    @(negedge clk);
                    if (!reset_n) abort = 1'b1;
                end
                for (int b = 0; b < W; b++) begin
                    for (int i = 0; i < CPB; i++) begin
                        @(negedge clk);
                        if (!reset_n) abort = 1'b1;
                    end
                    word[b] = tx_out;
                end
                for (int i = 0; i < CPB; i++) begin
                    @(negedge clk);
                    if (!reset_n) abort = 1'b1;
                end
                stop_bit = tx_out;
                lb_busy = 1'b0;
                if (!abort) begin
                    tx_frames++;
                    check("tx_stop_bit", stop_bit, 1);
                    if (exp_tx.size() == 0) unexpected("tx_frame", word);
                    else check("tx_frame", word, exp_tx.pop_front());
                end
            end
        end
    end

    initial begin
        int snap;
        int c;
        repeat (3) @(negedge clk);
        check("rst_tx_out", tx_out, 1);
        check("rst_write_fifo_n", write_fifo_n, 1);
        check("rst_read_fifo_n", read_fifo_n, 1);
        check("rst_write_regmap", write_regmap, 0);
        check("rst_regmap_address", regmap_address, 0);
        check("rst_regmap_write_data", regmap_write_data, 0);
        check("rst_finished_event", finished_event, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Config write to this chip
        exp_wr.push_back(16'h0301);
        send_word(54'h10312);
        repeat (10) @(negedge clk);
        check("cfgwr_count", n_regwr, 1);
        check("cfgwr_addr_hold", regmap_address, 8'h03);
        check("cfgwr_data_hold", regmap_write_data, 8'h01);
        check("cfgwr_tx_quiet", tx_starts, 0);

        // Config read: reply frame
        exp_tx.push_back(54'hA50313);
        send_word(54'h313);
        wait_frames(1, 300);
        check("cfgrd_no_write", n_regwr, 1);

        // Foreign chip ID: forwarded unchanged
        exp_tx.push_back(54'h20_0000_0001_0316);
        send_word(54'h20_0000_0001_0316);
        wait_frames(2, 300);
        check("fwd_no_write", n_regwr, 1);

        // Same packet with bad parity: dropped
        send_word(54'h10316);
        repeat (300) @(negedge clk);
        check("badpar_tx_quiet", tx_starts, 2);
        check("badpar_no_write", n_regwr, 1);

        // Back-to-back events; low byte of pre_event is discarded
        exp_ev.push_back(54'h1_0000_0011);
        exp_ev.push_back(54'h20_0003_0000_0011);
        pre_event  = 53'h1_0000_0000;
        load_event = 1'b1;
        @(negedge clk);
        pre_event  = 53'h3_0000_00FF;
        @(negedge clk);
        load_event = 1'b0;
        repeat (5) @(negedge clk);
        check("event_count", n_evwr, 2);
        check("event_hold", finished_event, 54'h20_0003_0000_0011);
        check("event_strobe_idle", write_fifo_n, 1);

        // FIFO drain: fifo_empty held low until the looped-back frame completes
        exp_tx.push_back(fifo_word);
        fifo_empty = 1'b0;
        c = 0;
        while (tx_frames < 3 && c < 400) begin
            @(negedge clk);
            c++;
        end
        fifo_empty = 1'b1;
        check("fifo_frame_done", tx_frames, 3);
        check("fifo_read_count", n_rd, 1);
        repeat (10) @(negedge clk);

        // Reset in the middle of a forwarded frame
        exp_tx.push_back(54'h20_0000_0001_0316);
        send_word(54'h20_0000_0001_0316);
        c = 0;
        while (!lb_busy && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("midtx_started", lb_busy, 1);
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midtx_rst_tx_out", tx_out, 1);
        check("midtx_rst_addr", regmap_address, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_tx.delete();
        c = 0;
        while (lb_busy && c < 300) begin
            @(negedge clk);
            c++;
        end
        check("midtx_no_frame", tx_frames, 3);

        // RX glitch shorter than half a bit, then a good write to prove recovery
        snap = tx_starts;
        rx_in = 1'b0;
        @(negedge clk);
        rx_in = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_no_write", n_regwr, 1);
        check("glitch_tx_quiet", tx_starts, snap);
        exp_wr.push_back(16'h0301);
        send_word(54'h10312);
        repeat (10) @(negedge clk);
        check("recover_write", n_regwr, 2);

        check("tx_queue_empty", exp_tx.size(), 0);
        check("wr_queue_empty", exp_wr.size(), 0);
        check("ev_queue_empty", exp_ev.size(), 0);
        check("final_read_count", n_rd, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
